// File: rtl/pacman_mover.sv
// -----------------------------------------------------------------------------
// pacman_mover
// Frame-rate movement controller for Pac-Man. Once per VGA frame it probes the
// maze through a wall-lookup request/acknowledge handshake: first the buffered
// turn (if any), then straight ahead. The first clear probe becomes the new
// centre position. Keyboard keycodes are decoded every cycle into a pending
// turn request that waits until a frame can accept it.
//
// Ports
//   Clk, Reset        system clock; synchronous active-high reset
//   vs                VGA vertical sync (asynchronous), one frame tick per rise
//   keycode[7:0]      USB HID keycode
//   wall_req          probe request, held until an ack or a timeout
//   wall_x, wall_y    probe centre, stable while wall_req=1
//   wall_ack          one-cycle acknowledge from the wall lookup
//   wall_hit          probe blocked (qualified by wall_ack)
//   PacX, PacY        current centre position
//   PacDir            heading: 0 right, 1 left, 2 up, 3 down
//   moving            last completed frame produced a move
//   overrun           one-cycle pulse when a frame tick arrives while busy
// -----------------------------------------------------------------------------
module pacman_mover #(
   parameter logic [9:0] START_X = 10'd320,
   parameter logic [9:0] START_Y = 10'd240,
   parameter logic [9:0] STEP    = 10'd1,
   parameter logic [9:0] X_MIN   = 10'd0,
   parameter logic [9:0] X_MAX   = 10'd639,
   parameter logic [9:0] Y_MIN   = 10'd0,
   parameter logic [9:0] Y_MAX   = 10'd479,
   parameter logic [7:0] TIMEOUT = 8'd64
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       vs,
   input  logic [7:0] keycode,
   output logic       wall_req,
   output logic [9:0] wall_x,
   output logic [9:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [9:0] PacX,
   output logic [9:0] PacY,
   output logic [1:0] PacDir,
   output logic       moving,
   output logic       overrun
);

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [1:0] {IDLE, TURN_Q, FWD_Q, UPDATE} state_t;

   // Candidate position one step away; ok=0 means it left the vertical range.
   typedef struct packed {
      logic       ok;
      logic [9:0] x;
      logic [9:0] y;
   } cand_t;

   // Arithmetic is done on 11-bit signed values so that 0 - STEP is negative
   // instead of aliasing to a large unsigned coordinate.
   function automatic cand_t next_pos(input logic [1:0] dir,
                                      input logic [9:0] px,
                                      input logic [9:0] py);
      logic signed [10:0] cx;
      logic signed [10:0] cy;
      logic signed [10:0] dlt;
      cand_t              c;
      cx  = signed'({1'b0, px});
      cy  = signed'({1'b0, py});
      dlt = signed'({1'b0, STEP});
      case (dir)
         DIR_RIGHT: cx = cx + dlt;
         DIR_LEFT:  cx = cx - dlt;
         DIR_UP:    cy = cy - dlt;
         default:   cy = cy + dlt;
      endcase
      // Horizontal edges are a tunnel: leave one side, appear on the other.
      if (cx < signed'({1'b0, X_MIN}))      cx = signed'({1'b0, X_MAX});
      else if (cx > signed'({1'b0, X_MAX})) cx = signed'({1'b0, X_MIN});
      c.ok = (cy >= signed'({1'b0, Y_MIN})) && (cy <= signed'({1'b0, Y_MAX}));
      c.x  = cx[9:0];
      c.y  = cy[9:0];
      return c;
   endfunction

   // Registered state
   state_t     state;
   logic       vs_s1, vs_s2, vs_s3;
   logic       tick;
   logic [7:0] tmo_cnt;
   logic       pend_valid;
   logic [1:0] pend_dir;

   // Next-state values
   state_t     state_nxt;
   logic       req_nxt;
   logic [9:0] wx_nxt, wy_nxt;
   logic [7:0] cnt_nxt;
   logic [9:0] x_nxt, y_nxt;
   logic [1:0] dir_nxt;
   logic       moving_nxt;
   logic       pv_nxt;
   logic [1:0] pd_nxt;
   logic       launch_fwd;

   logic       key_valid;
   logic [1:0] key_dir;
   logic       ack_ok;
   logic       timed_out;
   cand_t      turn_c;
   cand_t      fwd_c;

   assign turn_c = next_pos(pend_dir, PacX, PacY);
   assign fwd_c  = next_pos(PacDir, PacX, PacY);

   // An ack in the very first cycle of a probe is not honoured; the counter is
   // still 0 then, which doubles as that qualifier.
   assign ack_ok    = wall_req && wall_ack && (tmo_cnt != 8'd0);
   assign timed_out = wall_req && !ack_ok && (tmo_cnt == TIMEOUT - 8'd1);

   always_comb begin
      key_valid = 1'b1;
      key_dir   = DIR_RIGHT;
      case (keycode)
         8'h07, 8'h4F: key_dir = DIR_RIGHT;
         8'h04, 8'h50: key_dir = DIR_LEFT;
         8'h1A, 8'h52: key_dir = DIR_UP;
         8'h16, 8'h51: key_dir = DIR_DOWN;
         default:      key_valid = 1'b0;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      req_nxt    = wall_req;
      wx_nxt     = wall_x;
      wy_nxt     = wall_y;
      cnt_nxt    = tmo_cnt;
      x_nxt      = PacX;
      y_nxt      = PacY;
      dir_nxt    = PacDir;
      moving_nxt = moving;
      pv_nxt     = pend_valid;
      pd_nxt     = pend_dir;
      launch_fwd = 1'b0;

      case (state)
         IDLE: begin
            if (tick) begin
               // A turn whose target is off the top/bottom counts as blocked
               // without a probe, so it falls straight through to forward.
               if (pend_valid && turn_c.ok) begin
                  state_nxt = TURN_Q;
                  req_nxt   = 1'b1;
                  wx_nxt    = turn_c.x;
                  wy_nxt    = turn_c.y;
                  cnt_nxt   = 8'd0;
               end else begin
                  launch_fwd = 1'b1;
               end
            end
         end
         TURN_Q: begin
            cnt_nxt = tmo_cnt + 8'd1;
            if (ack_ok && !wall_hit) begin
               dir_nxt   = pend_dir;
               pv_nxt    = 1'b0;
               req_nxt   = 1'b0;
               state_nxt = UPDATE;
            end else if (ack_ok || timed_out) begin
               launch_fwd = 1'b1;
            end
         end
         FWD_Q: begin
            cnt_nxt = tmo_cnt + 8'd1;
            if (ack_ok && !wall_hit) begin
               req_nxt   = 1'b0;
               state_nxt = UPDATE;
            end else if (ack_ok || timed_out) begin
               req_nxt    = 1'b0;
               moving_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end
         default: begin  // UPDATE: wall_x/wall_y still hold the accepted probe
            x_nxt      = wall_x;
            y_nxt      = wall_y;
            moving_nxt = 1'b1;
            state_nxt  = IDLE;
         end
      endcase

      // Forward probe, entered from IDLE or after a blocked turn. When coming
      // from TURN_Q the request stays high and is re-armed with new coordinates.
      if (launch_fwd) begin
         if (fwd_c.ok) begin
            state_nxt = FWD_Q;
            req_nxt   = 1'b1;
            wx_nxt    = fwd_c.x;
            wy_nxt    = fwd_c.y;
            cnt_nxt   = 8'd0;
         end else begin
            state_nxt  = IDLE;
            req_nxt    = 1'b0;
            moving_nxt = 1'b0;
         end
      end

      // A key in the same cycle a turn is accepted wins: it re-arms the pending
      // turn with the new direction.
      if (key_valid) begin
         pv_nxt = 1'b1;
         pd_nxt = key_dir;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         vs_s1      <= 1'b0;
         vs_s2      <= 1'b0;
         vs_s3      <= 1'b0;
         tick       <= 1'b0;
         tmo_cnt    <= 8'd0;
         wall_req   <= 1'b0;
         wall_x     <= 10'd0;
         wall_y     <= 10'd0;
         PacX       <= START_X;
         PacY       <= START_Y;
         PacDir     <= DIR_RIGHT;
         moving     <= 1'b0;
         overrun    <= 1'b0;
         pend_valid <= 1'b0;
         pend_dir   <= DIR_RIGHT;
      end else begin
         vs_s1      <= vs;
         vs_s2      <= vs_s1;
         vs_s3      <= vs_s2;
         tick       <= vs_s2 & ~vs_s3;
         state      <= state_nxt;
         tmo_cnt    <= cnt_nxt;
         wall_req   <= req_nxt;
         wall_x     <= wx_nxt;
         wall_y     <= wy_nxt;
         PacX       <= x_nxt;
         PacY       <= y_nxt;
         PacDir     <= dir_nxt;
         moving     <= moving_nxt;
         overrun    <= tick && (state != IDLE);
         pend_valid <= pv_nxt;
         pend_dir   <= pd_nxt;
      end
   end

endmodule

// File: tb/tb_pacman_mover.sv
// -----------------------------------------------------------------------------
// tb_pacman_mover
// Scoreboarded bench for pacman_mover. A frame-level reference model pushes
// expected probe coordinates and expected end-of-frame results into queues;
// a negedge monitor acts as the wall lookup, pops and compares probes as they
// are acknowledged, and pops frame results as frames complete.
// -----------------------------------------------------------------------------
module tb_pacman_mover;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       vs = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       wall_req;
   logic [9:0] wall_x, wall_y;
   logic       wall_ack, wall_hit;
   logic [9:0] PacX, PacY;
   logic [1:0] PacDir;
   logic       moving, overrun;

   pacman_mover dut (
      .Clk(Clk), .Reset(Reset), .vs(vs), .keycode(keycode),
      .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
      .wall_ack(wall_ack), .wall_hit(wall_hit),
      .PacX(PacX), .PacY(PacY), .PacDir(PacDir),
      .moving(moving), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   // Wall lookup environment
   bit ack_drv = 0, hit_drv = 0;
   bit manual = 0, ack_man = 0, hit_man = 0;
   bit no_ack = 0;
   int ack_delay = 1;
   int wall_mode = 0;
   int seed = 0;
   int age = 0;
   assign wall_ack = manual ? ack_man : ack_drv;
   assign wall_hit = manual ? hit_man : hit_drv;

   int errors = 0;
   int checks = 0;

   typedef struct {int x; int y;} probe_t;
   typedef struct {int x; int y; int dir; int mov;} res_t;
   probe_t probe_q[$];
   res_t   res_q[$];
   probe_t p_exp;
   res_t   r_exp;
   int frames_done = 0, frames_checked = 0, over_seen = 0;

   // Reference model state
   int mx, my, mdir, mpv, mpd, mmov;

   logic [7:0] keys [12] = '{8'h07, 8'h4F, 8'h04, 8'h50, 8'h1A, 8'h52,
                             8'h16, 8'h51, 8'h00, 8'h05, 8'h2C, 8'hFF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // The maze seen by the lookup.
   function automatic bit wall_fn(input int x, input int y);
      case (wall_mode)
         1:       return ((x * 7 + y * 13 + seed) % 4) == 0;
         2:       return (x == 320) && (y == 239);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int key_to_dir(input logic [7:0] k);
      case (k)
         8'h07, 8'h4F: return 0;
         8'h04, 8'h50: return 1;
         8'h1A, 8'h52: return 2;
         8'h16, 8'h51: return 3;
         default:      return -1;
      endcase
   endfunction

   // One attempted step in direction d; records the probe the lookup will see.
   task automatic model_try(input int d, output bit moved);
      int cx, cy;
      cx = mx;
      cy = my;
      moved = 0;
      case (d)
         0: cx = cx + 1;
         1: cx = cx - 1;
         2: cy = cy - 1;
         default: cy = cy + 1;
      endcase
      if (cx < 0) cx = 639;
      else if (cx > 639) cx = 0;
      if (cy < 0 || cy > 479) return;
      if (!no_ack) probe_q.push_back('{cx, cy});
      if (no_ack || wall_fn(cx, cy)) return;
      mx = cx;
      my = cy;
      moved = 1;
   endtask

   task automatic model_frame();
      bit ok;
      ok = 0;
      if (mpv != 0) begin
         model_try(mpd, ok);
         if (ok) begin
            mdir = mpd;
            mpv  = 0;
         end
      end
      if (!ok) model_try(mdir, ok);
      mmov = ok ? 1 : 0;
      res_q.push_back('{mx, my, mdir, mmov});
   endtask

   // Lookup responder + monitor
   always @(negedge Clk) begin
      if (!wall_req || ack_drv || manual || no_ack) begin
         // After an honoured ack a still-high request is a fresh probe whose
         // first cycle is this one.
         age = (wall_req && ack_drv && !manual && !no_ack) ? 1 : 0;
         ack_drv = 0;
         hit_drv = 0;
      end else begin
         if (age >= ack_delay) begin
            ack_drv = 1;
            hit_drv = wall_fn(int'(wall_x), int'(wall_y));
            if (probe_q.size() == 0) begin
               check("probe_unexpected", 32'd1, 32'd0);
            end else begin
               p_exp = probe_q.pop_front();
               check("probe_x", 32'(wall_x), p_exp.x);
               check("probe_y", 32'(wall_y), p_exp.y);
            end
         end
         age++;
      end
      if (overrun) over_seen++;
      while (frames_checked < frames_done && res_q.size() > 0) begin
         r_exp = res_q.pop_front();
         check("frame_x", 32'(PacX), r_exp.x);
         check("frame_y", 32'(PacY), r_exp.y);
         check("frame_dir", 32'(PacDir), r_exp.dir);
         check("frame_moving", 32'(moving), r_exp.mov);
         frames_checked++;
      end
   end

   task automatic reset_dut();
      @(negedge Clk);
      Reset = 1;
      vs = 0;
      keycode = 8'h00;
      repeat (2) @(negedge Clk);
      Reset = 0;
      mx = 320; my = 240; mdir = 0; mpv = 0; mmov = 0;
   endtask

   task automatic press_key(input logic [7:0] k);
      int d;
      @(negedge Clk);
      keycode = k;
      d = key_to_dir(k);
      if (d >= 0) begin
         mpv = 1;
         mpd = d;
      end
      @(negedge Clk);
      keycode = 8'h00;
   endtask

   // Issues one vs pulse (optionally a second one mid-frame) and waits for the
   // frame to settle. Latencies are counted in clock edges from the vs rise.
   task automatic run_frame(input int second_vs, output int req_lat,
                            output int upd_lat, output int req_len);
      logic [9:0] x0, y0;
      int quiet;
      bit done;
      model_frame();
      x0 = PacX;
      y0 = PacY;
      req_lat = 0; upd_lat = 0; req_len = 0; quiet = 0; done = 0;
      @(negedge Clk);
      vs = 1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge Clk);
         if (c == 3) vs = 0;
         if (second_vs != 0 && c == second_vs) vs = 1;
         if (second_vs != 0 && c == second_vs + 3) vs = 0;
         if (wall_req) begin
            req_len++;
            if (req_lat == 0) req_lat = c;
            quiet = 0;
         end else begin
            quiet++;
         end
         if (upd_lat == 0 && (PacX != x0 || PacY != y0)) upd_lat = c;
         if (c >= 5 && quiet >= 4 && (second_vs == 0 || c > second_vs + 8)) begin
            done = 1;
            break;
         end
      end
      if (!done) check("frame_budget", 32'd0, 32'd1);
      frames_done++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rl, ul, ln, n;
      bit got;

      // Reset state
      reset_dut();
      check("rst_PacX", 32'(PacX), 32'd320);
      check("rst_PacY", 32'(PacY), 32'd240);
      check("rst_PacDir", 32'(PacDir), 32'd0);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_wall_req", 32'(wall_req), 32'd0);
      check("rst_wall_x", 32'(wall_x), 32'd0);
      check("rst_wall_y", 32'(wall_y), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);

      // Three straight frames, no walls
      run_frame(0, rl, ul, ln);
      check("straight_req_lat", rl, 32'd4);
      check("straight_upd_lat", ul, 32'd7);
      run_frame(0, rl, ul, ln);
      run_frame(0, rl, ul, ln);
      check("t1_PacX", 32'(PacX), 32'd323);
      check("t1_moving", 32'(moving), 32'd1);

      // Blocked turn kept pending, accepted next frame
      reset_dut();
      wall_mode = 2;
      press_key(8'h52);
      run_frame(0, rl, ul, ln);
      check("failturn_upd_lat", ul, 32'd9);
      check("t2_PacX", 32'(PacX), 32'd321);
      check("t2_PacDir_kept", 32'(PacDir), 32'd0);
      run_frame(0, rl, ul, ln);
      check("turn_upd_lat", ul, 32'd7);
      check("t2_PacDir", 32'(PacDir), 32'd2);
      check("t2_PacY", 32'(PacY), 32'd239);

      // No ack at all: timeout
      wall_mode = 0;
      no_ack = 1;
      run_frame(0, rl, ul, ln);
      check("timeout_req_len", ln, 32'd64);
      check("timeout_moving", 32'(moving), 32'd0);
      no_ack = 0;

      // Second vs while a probe is outstanding
      ack_delay = 20;
      check("overrun_before", over_seen, 32'd0);
      run_frame(6, rl, ul, ln);
      check("overrun_pulses", over_seen, 32'd1);
      ack_delay = 1;

      // Horizontal tunnel: run left to X=0, then wrap both ways
      press_key(8'h50);
      n = 0;
      while (mx != 0 && n < 700) begin
         run_frame(0, rl, ul, ln);
         n++;
      end
      check("wrap_reached_0", 32'(PacX), 32'd0);
      run_frame(0, rl, ul, ln);
      check("wrap_left_PacX", 32'(PacX), 32'd639);
      press_key(8'h07);
      run_frame(0, rl, ul, ln);
      check("wrap_right_PacX", 32'(PacX), 32'd0);

      // Top edge: leaving the vertical range is a wall with no probe
      press_key(8'h1A);
      n = 0;
      while (my != 0 && n < 600) begin
         run_frame(0, rl, ul, ln);
         n++;
      end
      run_frame(0, rl, ul, ln);
      check("ytop_PacY", 32'(PacY), 32'd0);
      check("ytop_no_req", ln, 32'd0);
      check("ytop_moving", 32'(moving), 32'd0);

      // Randomised frames against the model
      seed = int'($urandom_range(0, 999));
      wall_mode = 1;
      for (int f = 0; f < 150; f++) begin
         ack_delay = int'($urandom_range(1, 4));
         no_ack = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) < 40) press_key(keys[$urandom_range(0, 11)]);
         run_frame(0, rl, ul, ln);
      end
      no_ack = 0;
      wall_mode = 0;

      // Reset one cycle after wall_req rises; a late ack is ignored
      repeat (3) @(negedge Clk);
      press_key(8'h07);
      no_ack = 1;
      got = 0;
      @(negedge Clk);
      vs = 1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if (c == 3) vs = 0;
         if (wall_req) begin
            got = 1;
            break;
         end
      end
      check("rst_mid_req_seen", 32'(got), 32'd1);
      Reset = 1;
      @(negedge Clk);
      check("rst_mid_wall_req", 32'(wall_req), 32'd0);
      check("rst_mid_PacX", 32'(PacX), 32'd320);
      check("rst_mid_PacY", 32'(PacY), 32'd240);
      Reset = 0;
      manual = 1;
      ack_man = 1;
      hit_man = 0;
      repeat (2) @(negedge Clk);
      ack_man = 0;
      repeat (4) @(negedge Clk);
      check("late_ack_wall_req", 32'(wall_req), 32'd0);
      check("late_ack_PacX", 32'(PacX), 32'd320);
      check("late_ack_PacY", 32'(PacY), 32'd240);
      check("late_ack_moving", 32'(moving), 32'd0);

      // Scoreboard drained
      repeat (3) @(negedge Clk);
      check("frames_checked", frames_checked, frames_done);
      check("probes_left", probe_q.size(), 32'd0);
      check("overrun_total", over_seen, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
